// File: rtl/booth_div.sv
// booth_div: 16-bit by 8-bit signed divider, one quotient bit per clock.
// Magnitudes are divided with an unsigned restoring loop and sign-corrected
// at the end. The quotient truncates toward zero, and the remainder takes the
// sign of the dividend.
// Optional feature macro: BOOTH_DIV_DBZ_EN. When it is defined, a zero divisor
// skips the calculation and is flagged on dbz. When it is not defined, dbz is
// tied low.
module booth_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [7:0]  B,
    output logic        busy,
    output logic        done,
    output logic [15:0] Q,
    output logic [7:0]  R,
    output logic        ovf,
    output logic        dbz
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg;
    logic [15:0] a_reg;
    logic [7:0]  b_reg;
    logic        sign_a_reg;
    logic        sign_q_reg;
    // |A| shifts out of the top while quotient bits shift in at the bottom
    logic [15:0] dvd_reg;
    logic [7:0]  bmag_reg;
    logic [7:0]  rem_reg;

    logic        accept;
    logic        skip_calc;
    logic        busy_next;
    logic        done_next;
    logic [15:0] amag;
    logic [7:0]  bmag;
    logic [8:0]  trial;
    logic        qbit;
    logic [7:0]  rem_next;
    logic [15:0] q_final;
    logic [7:0]  r_final;
    logic        ovf_final;
    logic        dbz_op;
    logic        busy_reg;
    logic        done_reg;
    logic [15:0] q_reg;
    logic [7:0]  r_reg;
    logic        ovf_reg;

    assign amag = A[15] ? (16'd0 - A) : A;
    assign bmag = B[7]  ? (8'd0 - B)  : B;

`ifdef BOOTH_DIV_DBZ_EN
    logic dbz_reg;
    assign skip_calc = (B == 8'd0);
    assign dbz_op    = (b_reg == 8'd0);
    assign dbz       = dbz_reg;
`else
    assign skip_calc = 1'b0;
    assign dbz_op    = 1'b0;
    assign dbz       = 1'b0;
`endif

    // The 9-bit partial remainder is the previous remainder with the next dividend bit appended
    always_comb begin
        trial    = {rem_reg, dvd_reg[15]};
        qbit     = (trial >= {1'b0, bmag_reg});
        // The difference is always below |B|, so it fits in 8 bits
        rem_next = qbit ? (trial[7:0] - bmag_reg) : trial[7:0];
    end

    // Sign-correct the magnitudes once the loop has finished
    always_comb begin
        q_final   = sign_q_reg ? (16'd0 - dvd_reg) : dvd_reg;
        r_final   = sign_a_reg ? (8'd0 - rem_reg) : rem_reg;
        // -32768 / -1 is the only quotient that cannot be represented
        ovf_final = (a_reg == 16'h8000) && (b_reg == 8'hFF);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a start request is honoured in IDLE or DONE, and is ignored in CALC
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = skip_calc ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (cnt_reg == 4'd15) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode; busy and done are registered, so they lag the state by one cycle
    always_comb begin
        accept    = start && (state_reg != CALC);
        busy_next = (state_reg == CALC);
        done_next = (state_reg == DONE);
    end

    // Operand capture on accept, then one restoring step per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= 4'd0;
            a_reg      <= 16'd0;
            b_reg      <= 8'd0;
            sign_a_reg <= 1'b0;
            sign_q_reg <= 1'b0;
            dvd_reg    <= 16'd0;
            bmag_reg   <= 8'd0;
            rem_reg    <= 8'd0;
        end else if (accept) begin
            cnt_reg    <= 4'd0;
            a_reg      <= A;
            b_reg      <= B;
            sign_a_reg <= A[15];
            sign_q_reg <= A[15] ^ B[7];
            dvd_reg    <= amag;
            bmag_reg   <= bmag;
            rem_reg    <= 8'd0;
        end else if (state_reg == CALC) begin
            cnt_reg    <= cnt_reg + 4'd1;
            dvd_reg    <= {dvd_reg[14:0], qbit};
            rem_reg    <= rem_next;
        end
    end

    // Registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            done_reg <= done_next;
        end
    end

    // Result registers hold their values until the next completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg   <= 16'd0;
            r_reg   <= 8'd0;
            ovf_reg <= 1'b0;
        end else if (state_reg == DONE) begin
            if (dbz_op) begin
                q_reg   <= 16'd0;
                r_reg   <= 8'd0;
                ovf_reg <= 1'b0;
            end else begin
                q_reg   <= q_final;
                r_reg   <= r_final;
                ovf_reg <= ovf_final;
            end
        end
    end

`ifdef BOOTH_DIV_DBZ_EN
    // Divide-by-zero flag is updated together with the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbz_reg <= 1'b0;
        end else if (state_reg == DONE) begin
            dbz_reg <= dbz_op;
        end
    end
`endif

    assign busy = busy_reg;
    assign done = done_reg;
    assign Q    = q_reg;
    assign R    = r_reg;
    assign ovf  = ovf_reg;

endmodule

// File: doc/booth_div.md
BOOTH_DIV -- requirements
Module: booth_div

Interface
REQ-001 Parameters: none; operand widths are fixed at a 16-bit dividend and an 8-bit divisor.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin a divide; sampled on the rising edge of clk.
REQ-006 A  input  16  signed two's-complement dividend.
REQ-007 B  input  8  signed two's-complement divisor.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  one-cycle pulse that marks Q/R/ovf/dbz as valid.
REQ-010 Q  output  16  signed quotient.
REQ-011 R  output  8  signed remainder.
REQ-012 ovf  output  1  quotient overflow flag.
REQ-013 dbz  output  1  divide-by-zero flag.

Function
REQ-014 The block SHALL implement three states: IDLE, CALC and DONE.
REQ-015 start SHALL be accepted only in IDLE or DONE; start in CALC SHALL be ignored, and the operands in flight SHALL NOT change.
REQ-016 On the accepting edge, the block SHALL latch A and B, the sign of A, and the sign of A XOR B, plus the unsigned magnitudes |A| (16 bit) and |B| (8 bit).
REQ-017 CALC SHALL run an unsigned restoring algorithm with a 9-bit partial remainder, producing one quotient bit per cycle from the MSB down, for exactly 16 cycles.
REQ-018 Sign correction: the quotient SHALL truncate toward zero, the remainder SHALL take the sign of A, and |R| SHALL be less than |B|.
REQ-019 Latency: for start accepted at edge N, busy SHALL be 1 from edge N+1 through edge N+16, and done=1 with busy=0 SHALL hold for the cycle following edge N+17.
REQ-020 DONE SHALL last one cycle and then go to IDLE, unless start is asserted in DONE, in which case the block SHALL go directly into a new CALC.
REQ-021 Q, R, ovf and dbz SHALL hold their last values until the next done.
REQ-022 ovf SHALL be 1 only for A=-32768 with B=-1; in that case Q SHALL be -32768 (wrapped) and R SHALL be 0.
REQ-023 Simultaneous events: reset SHALL take priority over start.
REQ-024 A start arriving in the same cycle that done is high SHALL be accepted.

Reset
REQ-025 While rst_n=0, regardless of clk, the block SHALL force: state IDLE, busy=0, done=0, Q=0, R=0, ovf=0, dbz=0.
REQ-026 Reset asserted mid-CALC SHALL abort the operation with no done pulse.
REQ-027 After reset is released, the first start SHALL behave per REQ-019.

Configuration
REQ-028 With BOOTH_DIV_DBZ_EN defined, B=0 on an accepted start SHALL skip CALC and go to DONE in the next cycle.
REQ-029 In that B=0 case, done SHALL be high in the cycle after edge N+1, with dbz=1, Q=0, R=0, ovf=0.
REQ-030 Without BOOTH_DIV_DBZ_EN, dbz SHALL be tied 0.
REQ-031 Without BOOTH_DIV_DBZ_EN, B=0 SHALL run the normal 17-cycle latency, and Q/R SHALL be unspecified (not checked).

Verification
REQ-032 A=100, B=7 -> Q=14, R=2, ovf=0, dbz=0, done exactly 17 edges after the start edge, busy high for 16 cycles.
REQ-033 Sign mix: (-100,7) -> Q=-14, R=-2; (100,-7) -> Q=-14, R=2; (-100,-7) -> Q=14, R=-2.
REQ-034 Extremes: (-32768,-1) -> Q=-32768, R=0, ovf=1; (-32768,-128) -> Q=256, R=0; (32767,-128) -> Q=-255, R=127.
REQ-035 Divide by zero, B=0 with A=55: with BOOTH_DIV_DBZ_EN, done one cycle after the start edge with dbz=1, Q=0, R=0; without the macro, done at 17 cycles and dbz=0.
REQ-036 Back-to-back and mid-op start: start held high continuously gives done every 17 cycles; a start with new operands at CALC cycle 5 is ignored and the original result is returned.
REQ-037 Reset mid-operation: rst_n pulsed low at CALC cycle 8 -> all outputs 0 immediately, no done pulse; a subsequent (100,7) -> Q=14, R=2 at 17 cycles.
